// File: rtl/mb_mem_pkg.sv
// Shared definitions for the multi-bank memory requester slice.
// Purpose : bank geometry, command opcode encodings and the FSM state type
//           used by the requester, its interface and its read FIFO.
// Contents: NUM_BANKS / BANK_W  - number of memory banks and bank-select width
//           OP_FILL / OP_READ   - values carried on cmd_op
//           mb_state_e          - requester FSM states
package mb_mem_pkg;

  localparam int NUM_BANKS = 4;
  localparam int BANK_W    = 2;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_READ = 2'd2
  } mb_state_e;

endpackage

// File: rtl/multi_bank_mem_requester_if.sv
// Bundle of every handshake and memory-side signal of the requester.
// Purpose : lets the requester and its environment exchange the command,
//           fill-data, read-data and memory buses through one port.
// Modports: master - the requester itself (accepts commands, drives memory)
//           slave  - the environment (datapath + memory model)
// Signals : cmd_*  command channel (valid/ready, op, bank, addr, len)
//           wr_*   fill-data channel (valid/ready, data)
//           rd_*   read-data channel (valid/ready, data)
//           busy   requester activity flag
//           mem_*  memory port (we, bank_sel, addr, din, dout)
interface multi_bank_mem_requester_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 6
);
  import mb_mem_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [BANK_W-1:0]     cmd_bank;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  busy;

  logic                  mem_we;
  logic [BANK_W-1:0]     mem_bank_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout;

  modport master (
    input  cmd_valid, cmd_op, cmd_bank, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  mem_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy,
    output mem_we, mem_bank_sel, mem_addr, mem_din
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bank, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output mem_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
    input  mem_we, mem_bank_sel, mem_addr, mem_din
  );

endinterface

// File: rtl/mb_rd_skid_fifo.sv
// Two-entry synchronous FIFO that buffers memory read data for the requester.
// Purpose : decouples the fixed one-cycle memory latency from a consumer
//           that may stall at any time.
// Ports   : clk, rst_n      clock, asynchronous active-low reset
//           push_i          write push_data_i this cycle
//           push_data_i     word to store
//           pop_i           consumer took the head word this cycle
//           count_o         entries currently held (0..2)
//           valid_o         head word available
//           data_o          head word
module mb_rd_skid_fifo #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] store_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  // Storage is cleared on reset so the head word reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q[0] <= '0;
      store_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      if (push_i) begin
        store_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign valid_o = (count_q != 2'd0);
  assign data_o  = store_q[rd_ptr_q];

endmodule

// File: rtl/multi_bank_mem_requester.sv
// Burst initiator for a 4-bank memory with one-cycle registered read data.
// Purpose : accepts one FILL or READ command at a time and walks a linear
//           address range {bank, addr} for cmd_len+1 words, writing fill
//           data into the memory or streaming read data out through a
//           two-entry FIFO that tolerates any rd_ready pattern.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    master view of multi_bank_mem_requester_if
//                  (command, fill data, read data, busy, memory port)
module multi_bank_mem_requester
  import mb_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  multi_bank_mem_requester_if.master  bus
);

  // Bank and address form one counter so the wrap into the next bank
  // (and from bank 3 back to bank 0) falls out of plain binary carry.
  localparam int LIN_W = BANK_W + ADDR_WIDTH;

  mb_state_e             state_q, state_d;
  logic [LIN_W-1:0]      cur_q, cur_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [DATA_WIDTH-1:0] din_hold_q, din_hold_d;
  logic                  inflight_q;
  logic                  alive_q;

  logic                  issue;
  logic                  cmd_ready;
  logic                  wr_ready;
  logic                  mem_we;
  logic                  pop;
  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [2:0]            occupancy;

  // Words already buffered or on their way, minus the one leaving this
  // cycle; keeping this below two guarantees the FIFO never overflows.
  assign pop       = fifo_valid & bus.rd_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

  // State register. alive_q holds cmd_ready low during reset and lets it
  // rise one cycle after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      remain_q   <= '0;
      din_hold_q <= '0;
      inflight_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      remain_q   <= remain_d;
      din_hold_q <= din_hold_d;
      inflight_q <= issue;
      alive_q    <= 1'b1;
    end
  end

  // Next-state and handshake logic. A new command waits for the last
  // in-flight read to land so its data cannot mix with the next burst.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    remain_d   = remain_q;
    din_hold_d = din_hold_q;
    issue      = 1'b0;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    mem_we     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = alive_q & ~inflight_q;
        if (bus.cmd_valid && cmd_ready) begin
          cur_d    = {bus.cmd_bank, bus.cmd_addr};
          remain_d = bus.cmd_len;
          state_d  = (bus.cmd_op == OP_READ) ? ST_READ : ST_FILL;
        end
      end

      ST_FILL: begin
        wr_ready = 1'b1;
        mem_we   = bus.wr_valid;
        if (bus.wr_valid) begin
          din_hold_d = bus.wr_data;
          cur_d      = cur_q + LIN_W'(1);
          remain_d   = remain_q - LEN_WIDTH'(1);
          if (remain_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_READ: begin
        if (occupancy < 3'd2) begin
          issue    = 1'b1;
          cur_d    = cur_q + LIN_W'(1);
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == '0) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mb_rd_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (bus.mem_dout),
    .pop_i       (pop),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .data_o      (fifo_data)
  );

  // Memory write data follows the fill channel live; outside FILL it keeps
  // the last word written so the memory data bus does not toggle needlessly.
  assign bus.mem_we       = mem_we;
  assign bus.mem_bank_sel = cur_q[LIN_W-1:ADDR_WIDTH];
  assign bus.mem_addr     = cur_q[ADDR_WIDTH-1:0];
  assign bus.mem_din      = (state_q == ST_FILL) ? bus.wr_data : din_hold_q;

  assign bus.cmd_ready = cmd_ready;
  assign bus.wr_ready  = wr_ready;
  assign bus.rd_valid  = fifo_valid;
  assign bus.rd_data   = fifo_data;
  assign bus.busy      = (state_q != ST_IDLE) | inflight_q | (fifo_count != 2'd0);

endmodule

// File: tb/tb_multi_bank_mem_requester.sv
// Directed self-checking bench for multi_bank_mem_requester.
// A behavioural 4x16 memory with one-cycle registered read data sits on the
// memory side; bursts are driven through the interface and every observed
// value is compared against hand-computed expectations.
module tb_multi_bank_mem_requester;
  import mb_mem_pkg::*;

  logic clk;
  logic rst_n;
  int   compareCount  = 0;
  int   mismatchCount = 0;
  logic [7:0] tbMem [4][16];

  multi_bank_mem_requester_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(6)) bus ();

  multi_bank_mem_requester #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .LEN_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: synchronous write, registered read (old data on collision)
  always @(posedge clk) begin
    if (bus.mem_we) tbMem[bus.mem_bank_sel][bus.mem_addr] <= bus.mem_din;
    bus.mem_dout <= tbMem[bus.mem_bank_sel][bus.mem_addr];
  end

  // Global time limit so the bench always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Offers one command starting just after a rising edge; returns #1 after
  // the handshake edge.
  task automatic applyStimulus(input logic op, input logic [1:0] bank, input logic [3:0] addr, input logic [5:0] len);
    bus.cmd_op    = op;
    bus.cmd_bank  = bank;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready_before_cmd", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // FILL of len+1 words firstData, firstData+1, ...; gap idle cycles precede each word
  task automatic fillBurst(input logic [1:0] bank, input logic [3:0] addr, input logic [5:0] len,
                           input logic [7:0] firstData, input int gap);
    logic [5:0] lin;
    applyStimulus(OP_FILL, bank, addr, len);
    lin = {bank, addr};
    for (int i = 0; i <= int'(len); i++) begin
      for (int g = 0; g < gap; g++) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
        checkOutput("fill_we_gap", bus.mem_we, 0);
        checkOutput("fill_wr_ready_gap", bus.wr_ready, 1);
        checkOutput("fill_addr_gap", {26'd0, bus.mem_bank_sel, bus.mem_addr}, {26'd0, lin});
        @(posedge clk);
        #1;
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'(firstData + 8'(i));
      @(negedge clk);
      checkOutput("fill_we", bus.mem_we, 1);
      checkOutput("fill_bank", bus.mem_bank_sel, {30'd0, lin[5:4]});
      checkOutput("fill_addr", bus.mem_addr, {28'd0, lin[3:0]});
      checkOutput("fill_din", bus.mem_din, 8'(firstData + 8'(i)));
      @(posedge clk);
      #1;
      lin = lin + 6'd1;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    checkOutput("fill_done_cmd_ready", bus.cmd_ready, 1);
    checkOutput("fill_done_busy", bus.busy, 0);
    checkOutput("fill_done_we", bus.mem_we, 0);
    checkOutput("fill_done_din_hold", bus.mem_din, 8'(firstData + 8'(len)));
    @(posedge clk);
    #1;
  endtask

  // READ of len+1 words expected to equal firstData, firstData+1, ...
  // pattern 0: rd_ready always high; pattern 1: rd_ready 1-0-0-1 repeating.
  // expLatency != 0 also checks first-valid cycle and back-to-back delivery.
  task automatic readBurst(input logic [1:0] bank, input logic [3:0] addr, input logic [5:0] len,
                           input logic [7:0] firstData, input int pattern, input int expLatency);
    int got = 0;
    int firstValid = 0;
    int lastK = 0;
    int n = int'(len) + 1;
    bus.rd_ready = 1'b0;
    applyStimulus(OP_READ, bank, addr, len);
    for (int k = 1; k <= 300 && got < n; k++) begin
      bus.rd_ready = (pattern == 0) ? 1'b1 : ((k % 4 == 1) || (k % 4 == 0));
      @(negedge clk);
      if (bus.rd_valid && firstValid == 0) firstValid = k;
      if (bus.rd_valid && bus.rd_ready) begin
        checkOutput("rd_data", bus.rd_data, 8'(firstData + 8'(got)));
        got++;
        lastK = k;
      end
      @(posedge clk);
      #1;
    end
    bus.rd_ready = 1'b0;
    checkOutput("rd_word_count", got, n);
    if (expLatency != 0) begin
      checkOutput("rd_first_valid_cycle", firstValid, expLatency);
      checkOutput("rd_back_to_back", lastK - firstValid, n - 1);
    end
    @(negedge clk);
    checkOutput("rd_done_no_extra_valid", bus.rd_valid, 0);
    checkOutput("rd_done_busy", bus.busy, 0);
    checkOutput("rd_done_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 16; a++)
        tbMem[b][a] = 8'h00;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_FILL;
    bus.cmd_bank  = 2'd0;
    bus.cmd_addr  = 4'd0;
    bus.cmd_len   = 6'd0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    bus.rd_ready  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 0);
    checkOutput("rst_wr_ready", bus.wr_ready, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    checkOutput("rst_rd_data", bus.rd_data, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_bank_sel", bus.mem_bank_sel, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_din", bus.mem_din, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("cmd_ready_before_first_edge", bus.cmd_ready, 0);
    @(negedge clk);
    checkOutput("cmd_ready_after_release", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // FILL bank 1 addr 2, 4 words, then read them back at full rate
    $display("[TB] fill (1,2) x4 then read back");
    fillBurst(2'd1, 4'd2, 6'd3, 8'hA0, 0);
    for (int i = 0; i < 4; i++)
      checkOutput("mem_after_fill1", tbMem[1][2+i], 8'(8'hA0 + 8'(i)));
    readBurst(2'd1, 4'd2, 6'd3, 8'hA0, 0, 3);

    // FILL across the bank boundary (3,14) -> (0,1) and read back
    $display("[TB] fill across bank wrap then read back");
    fillBurst(2'd3, 4'd14, 6'd3, 8'hB0, 0);
    checkOutput("mem_wrap_3_15", tbMem[3][15], 8'hB1);
    checkOutput("mem_wrap_0_0", tbMem[0][0], 8'hB2);
    checkOutput("mem_wrap_0_1", tbMem[0][1], 8'hB3);
    readBurst(2'd3, 4'd14, 6'd3, 8'hB0, 0, 3);

    // FILL with wr_valid every third cycle, then read with toggling rd_ready
    $display("[TB] gapped fill, then read with rd_ready 1-0-0-1");
    fillBurst(2'd0, 4'd4, 6'd7, 8'hC0, 2);
    readBurst(2'd0, 4'd4, 6'd7, 8'hC0, 1, 0);

    // Single-word accesses
    $display("[TB] length-one fill and read");
    fillBurst(2'd2, 4'd9, 6'd0, 8'h5A, 0);
    checkOutput("mem_single_neighbor", tbMem[2][10], 8'h00);
    readBurst(2'd2, 4'd9, 6'd0, 8'h5A, 0, 3);

    // READ stalled with two words buffered, then reset mid-burst
    $display("[TB] stalled read then reset mid-burst");
    bus.rd_ready = 1'b0;
    applyStimulus(OP_READ, 2'd0, 4'd4, 6'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_rd_valid", bus.rd_valid, 1);
    checkOutput("stall_rd_data_head", bus.rd_data, 8'hC0);
    checkOutput("stall_issue_addr", bus.mem_addr, 6);
    checkOutput("stall_busy", bus.busy, 1);
    @(negedge clk);
    checkOutput("stall_issue_addr_held", bus.mem_addr, 6);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rd_valid", bus.rd_valid, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_cmd_ready", bus.cmd_ready, 0);
    checkOutput("midrst_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    readBurst(2'd1, 4'd2, 6'd3, 8'hA0, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/multi_bank_mem_requester.md
# multi_bank_mem_requester

Burst initiator that drives a 4-bank, 1-cycle-read-latency synchronous memory. It accepts one fill or read command at a time: a start bank/address and a word count. For a fill, it streams write data into the memory; for a read, it streams memory contents out through a backpressure-safe read channel. It sits between the processing datapath and the multi-bank memory and owns all of the memory's `we`/`addr`/`din`/`bank_sel` inputs.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must equal the memory's data width.
- ADDR_WIDTH, 4, per-bank address width; must equal the memory's address width.
- LEN_WIDTH, 6, command length field width; burst length = cmd_len+1 (1..64 words).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_op  in  1  0 = FILL (write), 1 = READ.
- cmd_bank  in  2  start bank.
- cmd_addr  in  ADDR_WIDTH  start address within bank.
- cmd_len  in  LEN_WIDTH  words minus one.
- wr_valid  in  1  fill data offered.
- wr_ready  out  1  fill data accepted.
- wr_data  in  DATA_WIDTH  fill word.
- rd_valid  out  1  read word available.
- rd_ready  in  1  consumer accepts read word.
- rd_data  out  DATA_WIDTH  read word.
- busy  out  1  high whenever state ≠ IDLE or a read is in flight/buffered.
- mem_we  out  1  memory write enable.
- mem_bank_sel  out  2  memory bank select.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory registered read data (valid one cycle after the address edge).

## Operation
- FSM states: IDLE, FILL, READ.
- IDLE:
  - cmd_ready=1.
  - On the handshake edge, latch bank/addr into cur_bank/cur_addr and load remaining = cmd_len.
  - Go to FILL or READ according to cmd_op.
- Address sequencing:
  - Each issued word increments cur_addr modulo 2^ADDR_WIDTH.
  - When cur_addr wraps from all-ones to 0, cur_bank increments modulo 4 (bank 3 → bank 0).
  - A burst therefore walks linearly across banks.
- FILL:
  - wr_ready=1.
  - mem_we = wr_valid (combinational).
  - mem_din = wr_data.
  - Address and bank come from the cur_ registers.
  - Each wr handshake writes one word and advances the address.
  - After the handshake with remaining==0, return to IDLE.
- READ:
  - Issue a read (drive cur address, mem_we=0) when fifo_count + inflight − (rd_valid & rd_ready) < 2.
  - Each issue sets inflight for exactly one cycle.
  - In the following cycle, mem_dout is pushed into a 2-entry output FIFO.
  - After the issue with remaining==0, return to IDLE. The last in-flight word still lands in the FIFO.
  - cmd_ready stays 0 until inflight==0, so no new command is accepted while a read is in flight.
- Outside FILL, mem_we=0; mem_din holds its last value.
- The FIFO feeds rd_data/rd_valid in order. No word is ever dropped or duplicated under any rd_ready pattern.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - cmd_ready=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0.
  - mem_we=0, mem_bank_sel=0, mem_addr=0, mem_din=0.
  - FIFO empty, inflight=0, state IDLE.
- cmd_ready rises in the first cycle after rst_n deasserts.
- FILL: the first memory write is at the first edge after the command edge. Throughput is 1 word/cycle while wr_valid is held high.
- READ:
  - First issue is in the cycle after the command edge.
  - rd_valid first rises 3 cycles after the command edge.
  - Throughput is 1 word/cycle while rd_ready is held high.
  - With rd_ready=0, at most 2 words are buffered and issue stalls.
- A command with cmd_len=0 performs exactly one access.
- Reset mid-burst aborts immediately. Buffered and in-flight read data are discarded, and partial fill writes remain in memory.
- Simultaneous FIFO push and pop at count 2 cannot occur, because the issue rule prevents it.

## Structure
- Shared package mb_mem_pkg:
  - NUM_BANKS=4 and BANK_W=2.
  - Op encodings OP_FILL/OP_READ.
  - FSM state typedef.
- One sub-module: mb_rd_skid_fifo, a 2-entry synchronous FIFO with count output and async active-low reset.

## Test plan
- Reset, then FILL bank 1, addr 2, len 3 with data 0xA0..0xA3 → memory writes at (1,2)..(1,5); cmd_ready returns high the cycle after the last write.
- READ bank 1, addr 2, len 3 with rd_ready=1 → rd_data 0xA0, 0xA1, 0xA2, 0xA3 on 4 consecutive cycles; first rd_valid 3 cycles after the command edge.
- FILL bank 3, addr 14, len 3 → writes at (3,14), (3,15), (0,0), (0,1); read back in the same order.
- READ len 7 with rd_ready toggling 1-0-0-1 → 8 words, in order, no loss; mem address issue stalls while the FIFO is full.
- FILL with wr_valid gaps (valid every 3rd cycle) → mem_we pulses only on valid cycles; addresses stay contiguous.
- Assert rst_n=0 mid-READ with 2 words buffered → rd_valid=0 immediately; after release, cmd_ready=1 and a new READ returns correct data.
